// File: rtl/cpu_bus_pkg.sv
// Shared types for the 6502 bus responder: address regions, FSM states,
// window bases and the address decoder.
package cpu_bus_pkg;

  typedef enum logic [1:0] {RGN_RAM, RGN_PPU, RGN_CART, RGN_OPEN} region_e;
  typedef enum logic [1:0] {IDLE, RAM_RD, EXT_WAIT, EXT_DONE} state_e;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] PPU_BASE  = 16'h2000;
  localparam logic [15:0] OPEN_BASE = 16'h4000;
  localparam logic [15:0] CART_BASE = 16'h8000;

  function automatic region_e decode(input logic [15:0] a);
    if (a[15] == CART_BASE[15])            return RGN_CART;
    else if (a[15:13] == RAM_BASE[15:13])  return RGN_RAM;
    else if (a[15:13] == PPU_BASE[15:13])  return RGN_PPU;
    else                                   return RGN_OPEN;
  endfunction

endpackage

// File: rtl/bus_ram.sv
// Single-port work RAM with registered read; no reset on contents.
module bus_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    q
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)      mem[addr] <= wdata;
    else if (re) q         <= mem[addr];
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU-bus target: mirrored work RAM, PPU/cartridge forwarding over a
// req/ack channel with timeout, and open-bus return for unmapped space.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int RAM_AW  = 11,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        write,
  input  logic [7:0]  d_out,
  output logic [7:0]  d_in,
  output logic        ready,
  output logic        ext_req,
  output logic        ext_sel,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        bus_err
);

  state_e          state, state_nx;
  region_e         rgn;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      ob_q, ext_data_q, ram_q;
  logic            ram_we, ram_re, to_hit;

  assign rgn     = decode(addr);
  assign ext_req = (state == EXT_WAIT);
  assign to_hit  = (to_cnt == TO_W'(TIMEOUT));

  bus_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr[RAM_AW-1:0]),
    .wdata (d_out),
    .q     (ram_q)
  );

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    d_in     = ob_q;
    case (state)
      IDLE: begin
        case (rgn)
          RGN_RAM: begin
            if (write) begin
              // reset gates the write so a held-in-reset cycle cannot corrupt RAM
              ram_we = reset;
              ready  = 1'b1;
            end else begin
              ram_re   = 1'b1;
              state_nx = RAM_RD;
            end
          end
          RGN_PPU, RGN_CART: state_nx = EXT_WAIT;
          default:           ready    = 1'b1;
        endcase
      end
      RAM_RD: begin
        ready    = 1'b1;
        d_in     = ram_q;
        state_nx = IDLE;
      end
      EXT_WAIT: begin
        if (ext_ack || to_hit) state_nx = EXT_DONE;
      end
      EXT_DONE: begin
        ready    = 1'b1;
        d_in     = ext_data_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      to_cnt     <= '0;
      ob_q       <= 8'h00;
      ext_data_q <= 8'h00;
      bus_err    <= 1'b0;
      ext_sel    <= 1'b0;
      ext_we     <= 1'b0;
      ext_addr   <= 16'h0000;
      ext_wdata  <= 8'h00;
    end else begin
      state <= state_nx;
      if (ready) ob_q <= write ? d_out : d_in;
      case (state)
        IDLE: begin
          if (rgn == RGN_PPU || rgn == RGN_CART) begin
            ext_sel   <= (rgn == RGN_CART);
            ext_we    <= write;
            ext_addr  <= (rgn == RGN_CART) ? addr : {13'b0, addr[2:0]};
            ext_wdata <= d_out;
          end
        end
        EXT_WAIT: begin
          // ack takes priority over a coincident timeout
          if (ext_ack) begin
            if (!ext_we) ext_data_q <= ext_rdata;
          end else if (to_hit) begin
            ext_data_q <= ob_q;
            bus_err    <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        EXT_DONE: to_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Target side of the 6502 CPU bus. Decodes each CPU bus cycle (addr/write/d_out) and returns d_in and ready.
- Serves internal work RAM, mirrored across $0000-$1FFF.
- Forwards PPU-register ($2000-$3FFF, mirrored every 8) and cartridge ($8000-$FFFF) accesses to one external req/ack channel.
- Returns open-bus data for unmapped space; stretches CPU cycles via ready.

Parameters:
- RAM_AW, 11, work RAM address width (2 KiB); mirror = addr[RAM_AW-1:0].
- TIMEOUT, 15, max cycles waiting for ext_ack before forced completion.
- TO_W, 4, width of timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- addr  in  16  CPU address
- write  in  1  CPU write strobe (1 = write cycle)
- d_out  in  8  CPU write data
- d_in  out  8  read data to CPU
- ready  out  1  1 = current bus cycle completes at this clock edge
- ext_req  out  1  external access request, held until ack or timeout
- ext_sel  out  1  0 = PPU window, 1 = cartridge window
- ext_we  out  1  external write
- ext_addr  out  16  external address; PPU window = {13'b0, addr[2:0]}, cartridge = addr
- ext_wdata  out  8  external write data
- ext_rdata  in  8  external read data, valid with ext_ack
- ext_ack  in  1  single-cycle completion pulse
- bus_err  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- One clock; reset is synchronous and active-low (reset == 0 resets on the clk edge). Reset values: state IDLE, ext_req 0, ext_we 0, ext_sel 0, ext_addr 0, ext_wdata 0, bus_err 0, open-bus latch 0, timeout counter 0. RAM contents are not reset.
- A bus cycle begins on every clock in which state == IDLE. The CPU holds addr/write/d_out stable while ready == 0.
- Decode (combinational, from addr):
  - RAM: addr[15:13] == 000
  - PPU: addr[15:13] == 001
  - CART: addr[15] == 1
  - OPEN: everything else ($4000-$7FFF)
- States:
  - IDLE:
    - RAM write: RAM written at the edge; ready = 1; stay in IDLE.
    - RAM read: RAM read issued; ready = 0; next state RAM_RD.
    - PPU/CART: ready = 0; register ext_* from addr/write/d_out; next state EXT_WAIT.
    - OPEN: ready = 1; d_in = open-bus latch; writes are discarded; stay in IDLE.
  - RAM_RD: ready = 1; d_in = RAM q; next state IDLE. Latency is exactly 1 wait state.
  - EXT_WAIT:
    - ext_req = 1; ready = 0; counter increments each cycle.
    - On ext_ack: latch ext_rdata (reads); ext_req 0; next state EXT_DONE.
    - If counter == TIMEOUT and no ack: ext_req 0; bus_err 1; latched data = open-bus value; next state EXT_DONE.
    - Ack wins when ack and timeout coincide.
  - EXT_DONE: ready = 1; d_in = latched data; counter cleared; next state IDLE.
- ready is combinational from state and IDLE-cycle decode only. It never depends on ext_ack in the same cycle, so there is no combinational path from ext_ack to ready.
- Open-bus latch updates on every completed cycle (ready == 1): reads load the d_in value, writes load d_out. In all other cycles d_in = open-bus latch.
- ext_ack is ignored outside EXT_WAIT, so a late ack after timeout or reset is dropped.
- Reset mid-operation (any state) goes to IDLE with ext_req deasserted in the same edge. No RAM write occurs on a cycle with reset == 0.
- Minimum external latency: ack in the first EXT_WAIT cycle gives a 3-clock CPU cycle (IDLE, EXT_WAIT, EXT_DONE).

Decomposition:
- Package cpu_bus_pkg:
  - region enum (RGN_RAM, RGN_PPU, RGN_CART, RGN_OPEN)
  - state enum (IDLE, RAM_RD, EXT_WAIT, EXT_DONE)
  - window base constants
- Sub-module bus_ram: single-port synchronous RAM, 2**RAM_AW x 8, registered read, write-first ignored (no simultaneous read/write).

Test Plan:
- Reset: hold reset = 0 for 2 clocks, then 1 -> ready = 1 for addr $5000, d_in = $00, bus_err = 0, ext_req = 0.
- RAM mirror: write $A5 to $0012 (ready = 1 same cycle), then read $0812 and $1812 -> each read has ready = 0 then 1, d_in = $A5 on the ready cycle.
- PPU forward: read $3FFA with ack after 3 cycles and ext_rdata = $5C -> ext_sel = 0, ext_addr = $0002, ext_we = 0; ready is low 4 cycles, then d_in = $5C.
- Cartridge write: write $77 to $C000, ack on the first wait cycle -> ext_sel = 1, ext_we = 1, ext_wdata = $77; the following read of $4016 (open) returns $77.
- Timeout: read $8000 with no ack -> ext_req high 16 cycles then low, bus_err = 1, d_in = prior open-bus value; a late ack 2 cycles later has no effect.
- Reset mid-wait: assert reset in the 2nd EXT_WAIT cycle -> next cycle state IDLE, ext_req = 0, bus_err = 0; the RAM byte written earlier is intact when read back.
